// File: rtl/axistream_pkg.sv
// Shared definitions for the axistream pack/unpack blocks.
// Provides default element width and pack factor, the unpack FSM state type,
// and a clog2-style helper used to size element index counters.
package axistream_pkg;

    localparam int AXIS_DATA_WIDTH = 8;
    localparam int AXIS_NUM_PACK   = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } unpack_state_t;

    // Width of an index that can address n elements; never narrower than one
    // bit so a counter declaration stays legal for any pack factor.
    function automatic int idx_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/axistream_unpack.sv
// Purpose: splits each NUM_PACK-element packed word into single elements, element 0 (LSBs) first.
// Latency: 1 cycle from src handshake to element 0 on dest; then one element per dest handshake.
// Backpressure: holds one word; src_tready rises only when empty or the last element leaves this cycle.
//
// Ports:
//   clk, rst_n                         - clock, asynchronous active-low reset
//   src_tvalid/src_tready/src_tdata/src_tlast     - packed word input stream
//   dest_tvalid/dest_tready/dest_tdata/dest_tlast - element output stream
// Build option: AXISTREAM_UNPACK_WORD_TLAST_EN marks the last element of every
// word with dest_tlast; otherwise only words captured with src_tlast=1 do.
module axistream_unpack
    import axistream_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int NUM_PACK   = AXIS_NUM_PACK
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         src_tvalid,
    output logic                         src_tready,
    input  logic [NUM_PACK*DATA_WIDTH-1:0] src_tdata,
    input  logic                         src_tlast,
    output logic                         dest_tvalid,
    input  logic                         dest_tready,
    output logic [DATA_WIDTH-1:0]        dest_tdata,
    output logic                         dest_tlast
);

    localparam int                IDX_W    = idx_width(NUM_PACK);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_PACK - 1);

    unpack_state_t                   state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [NUM_PACK*DATA_WIDTH-1:0]  word_q, word_d;
    logic                            last_q, last_d;
    // Low through reset and until the first clock edge after release, so the
    // source is never told "ready" while the block is still held in reset.
    logic                            run_q, run_d;

    logic dest_hs;
    logic final_hs;
    logic src_hs;

    assign dest_hs  = (state_q == ST_DRAIN) && dest_tready;
    assign final_hs = dest_hs && (idx_q == IDX_LAST);
    assign src_hs   = src_tvalid && src_tready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            last_q  <= last_d;
            run_q   <= run_d;
        end
    end

    // Next-state logic. A src handshake can only occur when empty or on the
    // final-element handshake, so loading a new word takes priority and keeps
    // the block in DRAIN without a bubble.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        last_d  = last_q;
        run_d   = 1'b1;
        if (src_hs) begin
            state_d = ST_DRAIN;
            idx_d   = '0;
            word_d  = src_tdata;
            last_d  = src_tlast;
        end else if (dest_hs) begin
            if (idx_q == IDX_LAST) begin
                state_d = ST_EMPTY;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Output logic
    always_comb begin
        src_tready  = run_q && ((state_q == ST_EMPTY) || final_hs);
        dest_tvalid = (state_q == ST_DRAIN);
        dest_tdata  = word_q[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH];
`ifdef AXISTREAM_UNPACK_WORD_TLAST_EN
        dest_tlast  = (state_q == ST_DRAIN) && (idx_q == IDX_LAST);
`else
        dest_tlast  = (state_q == ST_DRAIN) && (idx_q == IDX_LAST) && last_q;
`endif
    end

endmodule

// File: tb/tb_axistream_unpack.sv
// Bench for axistream_unpack (DATA_WIDTH=8, NUM_PACK=4).
// Reference: a queue of pending elements; a word adds its four elements on
// acceptance, each dest handshake removes the front one.
module tb_axistream_unpack;

    logic        clk;
    logic        rst_n;
    logic        src_tvalid;
    logic        src_tready;
    logic [31:0] src_tdata;
    logic        src_tlast;
    logic        dest_tvalid;
    logic        dest_tready;
    logic [7:0]  dest_tdata;
    logic        dest_tlast;

    axistream_unpack #(.DATA_WIDTH(8), .NUM_PACK(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_tvalid  (src_tvalid),
        .src_tready  (src_tready),
        .src_tdata   (src_tdata),
        .src_tlast   (src_tlast),
        .dest_tvalid (dest_tvalid),
        .dest_tready (dest_tready),
        .dest_tdata  (dest_tdata),
        .dest_tlast  (dest_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [8:0] exp_q[$];   // {tlast, data}
    logic       up_edge;    // a clock edge has occurred since reset release
    logic       prev_stall;
    logic [9:0] prev_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) up_edge <= 1'b0;
        else        up_edge <= 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_dest_tvalid", {31'b0, dest_tvalid}, 32'd0);
            chk("rst_src_tready",  {31'b0, src_tready},  32'd0);
            chk("rst_dest_tdata",  {24'b0, dest_tdata},  32'd0);
            chk("rst_dest_tlast",  {31'b0, dest_tlast},  32'd0);
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            logic exp_vld, exp_rdy;
            exp_vld = exp_q.size() > 0;
            // One word of buffering: room appears when nothing is pending or
            // the only pending element leaves now.
            exp_rdy = up_edge && ((exp_q.size() == 0) || (exp_q.size() == 1 && dest_tready));
            chk("dest_tvalid", {31'b0, dest_tvalid}, {31'b0, exp_vld});
            chk("src_tready",  {31'b0, src_tready},  {31'b0, exp_rdy});
            if (exp_vld) begin
                chk("dest_tdata", {24'b0, dest_tdata}, {24'b0, exp_q[0][7:0]});
                chk("dest_tlast", {31'b0, dest_tlast}, {31'b0, exp_q[0][8]});
            end else begin
                chk("idle_tlast", {31'b0, dest_tlast}, 32'd0);
            end
            if (prev_stall)
                chk("stall_hold", {22'b0, dest_tvalid, dest_tlast, dest_tdata}, {22'b0, prev_out});
            prev_stall = dest_tvalid && !dest_tready;
            prev_out   = {dest_tvalid, dest_tlast, dest_tdata};
            if (dest_tvalid && dest_tready && exp_q.size() > 0)
                void'(exp_q.pop_front());
            if (src_tvalid && src_tready) begin
                for (int k = 0; k < 4; k++) begin
                    logic l;
`ifdef AXISTREAM_UNPACK_WORD_TLAST_EN
                    l = (k == 3);
`else
                    l = (k == 3) && src_tlast;
`endif
                    exp_q.push_back({l, src_tdata[k*8 +: 8]});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic l, output int waited);
        src_tvalid = 1'b1;
        src_tdata  = d;
        src_tlast  = l;
        waited     = 0;
        forever begin
            @(negedge clk);
            waited++;
            if (src_tready) break;
            if (waited > 200) begin
                errors++;
                $display("FAIL send_timeout: no src_tready for word %0h", d);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        src_tvalid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int   w;
    logic done;
    logic [7:0] lit[4];

    initial begin
        rst_n = 1'b0; src_tvalid = 1'b0; src_tdata = '0; src_tlast = 1'b0;
        dest_tready = 1'b1; done = 1'b0; prev_stall = 1'b0; prev_out = '0;
        #2;
        chk("reset_src_tready", {31'b0, src_tready}, 32'd0);
        chk("reset_dest_tvalid", {31'b0, dest_tvalid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("pre_edge_src_tready", {31'b0, src_tready}, 32'd0);
        @(posedge clk); #1;
        chk("post_edge_src_tready", {31'b0, src_tready}, 32'd1);

        // Single word, consecutive elements, tlast only with the last one.
        lit = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_word(32'h04030201, 1'b1, w);
        src_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("w1_data", {24'b0, dest_tdata}, {24'b0, lit[k]});
            chk("w1_last", {31'b0, dest_tlast}, {31'b0, k == 3});
        end
        idle(2);

        // Back-to-back words with no bubble.
        send_word(32'h44332211, 1'b0, w);
        chk("b2b_first_wait", w, 32'd1);
        send_word(32'h88776655, 1'b1, w);
        chk("b2b_second_wait", w, 32'd4);
        idle(6);

        // Stall at index 1.
        send_word(32'hDDCCBBAA, 1'b0, w);
        src_tvalid = 1'b0;
        @(negedge clk);
        chk("stall_e0", {24'b0, dest_tdata}, 32'hAA);
        @(posedge clk); #1 dest_tready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_held", {24'b0, dest_tdata}, 32'hBB);
        end
        @(posedge clk); #1 dest_tready = 1'b1;
        lit = '{8'hBB, 8'hCC, 8'hDD, 8'h00};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_resume", {24'b0, dest_tdata}, {24'b0, lit[k]});
        end
        idle(2);

        // Reset mid-drain discards the held word.
        send_word(32'h0D0C0B0A, 1'b0, w);
        src_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", {31'b0, dest_tvalid}, 32'd0);
        chk("midrst_tdata", {24'b0, dest_tdata}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_word(32'h14131211, 1'b0, w);
        src_tvalid = 1'b0;
        @(negedge clk);
        chk("after_rst_first", {24'b0, dest_tdata}, 32'h11);
        idle(5);

        // src_tlast=0 word.
        lit = '{8'h04, 8'h03, 8'h02, 8'h01};
        send_word(32'h01020304, 1'b0, w);
        src_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("nolast_data", {24'b0, dest_tdata}, {24'b0, lit[k]});
`ifdef AXISTREAM_UNPACK_WORD_TLAST_EN
            chk("nolast_last", {31'b0, dest_tlast}, {31'b0, k == 3});
`else
            chk("nolast_last", {31'b0, dest_tlast}, 32'd0);
`endif
        end
        idle(2);

        // Randomized traffic with random sink backpressure.
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                    send_word($urandom, 1'($urandom_range(0, 1)), w);
                end
                src_tvalid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    dest_tready = ($urandom_range(0, 3) != 0);
                end
                dest_tready = 1'b1;
            end
        join

        for (int c = 0; c < 100 && exp_q.size() > 0; c++) @(posedge clk);
        @(negedge clk);
        chk("drained", exp_q.size(), 32'd0);
        chk("final_tvalid", {31'b0, dest_tvalid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axistream_unpack.md
AXISTREAM_UNPACK -- requirements
Module: axistream_unpack

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning width of one element in bits.
REQ-002 SHALL have parameter NUM_PACK, default 4, meaning number of elements per packed word (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port src_tvalid, input, 1, meaning packed word valid.
REQ-006 SHALL have port src_tready, output, 1, meaning block accepts packed word.
REQ-007 SHALL have port src_tdata, input, NUM_PACK*DATA_WIDTH, meaning packed word; element k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port src_tlast, input, 1, meaning word ends a group.
REQ-009 SHALL have port dest_tvalid, output, 1, meaning element valid.
REQ-010 SHALL have port dest_tready, input, 1, meaning sink accepts element.
REQ-011 SHALL have port dest_tdata, output, DATA_WIDTH, meaning current element.
REQ-012 SHALL have port dest_tlast, output, 1, meaning final element of a group.

Function
REQ-013 SHALL implement two states: EMPTY (no word held) and DRAIN (word held, index idx of width clog2(NUM_PACK)).
REQ-014 SHALL, in EMPTY, drive src_tready=1 and dest_tvalid=0.
REQ-015 SHALL, on src handshake, register src_tdata and src_tlast, set idx=0, enter DRAIN; element 0 appears on dest the next cycle (latency 1).
REQ-016 SHALL, in DRAIN, drive dest_tvalid=1 and dest_tdata = held element idx (element 0 first, LSBs first).
REQ-017 SHALL hold dest_tdata, dest_tlast, dest_tvalid stable while dest_tvalid=1 and dest_tready=0.
REQ-018 SHALL, on dest handshake with idx<NUM_PACK-1, increment idx by 1.
REQ-019 SHALL, on dest handshake with idx=NUM_PACK-1, return to EMPTY unless a new word is accepted in the same cycle.
REQ-020 SHALL drive src_tready = EMPTY OR (dest handshake at idx=NUM_PACK-1), so back-to-back words stream with no bubble (combinational dest_tready-to-src_tready path permitted).
REQ-021 SHALL, on simultaneous final-element handshake and src handshake, load the new word, set idx=0, and remain in DRAIN.
REQ-022 SHALL drive dest_tlast=1 only at idx=NUM_PACK-1 of a word captured with src_tlast=1 (default build).
REQ-023 SHALL never drop, duplicate, or reorder elements; exactly NUM_PACK dest handshakes per src handshake.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force EMPTY, idx=0, dest_tvalid=0, dest_tlast=0, dest_tdata=0, held word=0, src_tready=0.
REQ-025 SHALL, on rst_n assertion mid-DRAIN, discard the held word; no partial word resumes after release.
REQ-026 SHALL drive src_tready=1 from the first clock edge after rst_n deasserts.

Configuration
REQ-027 SHALL honour macro AXISTREAM_UNPACK_WORD_TLAST_EN: when defined, dest_tlast=1 at idx=NUM_PACK-1 of every word regardless of src_tlast; when undefined, REQ-022 applies.

Structure
REQ-028 SHALL take DATA_WIDTH/NUM_PACK defaults and a clog2 index-width function from shared package axistream_pkg, common with axistream_pack.
REQ-029 SHALL be a single module with no sub-modules; element select is an inline indexed part-select.

Verification
REQ-030 SHALL verify: word 0x04030201, tlast=1, dest_tready=1 -> dest 0x01,0x02,0x03,0x04 on consecutive cycles, dest_tlast only with 0x04.
REQ-031 SHALL verify: two words 0x44332211, 0x88776655 back-to-back, dest_tready=1 -> 8 elements on 8 consecutive cycles, src_tready high on cycles accepting each word.
REQ-032 SHALL verify: dest_tready low 3 cycles at idx=1 of 0xDDCCBBAA -> dest_tdata held at 0xBB, no loss; sequence resumes 0xCC,0xDD.
REQ-033 SHALL verify: rst_n pulsed low after 2 elements of 0x0D0C0B0A -> dest_tvalid=0 immediately; next word 0x14131211 emits 0x11 first.
REQ-034 SHALL verify: word 0x01020304 with src_tlast=0 -> dest_tlast never asserted (default build); asserted on 0x01 with AXISTREAM_UNPACK_WORD_TLAST_EN defined.
REQ-035 SHALL verify: output feeding insertion_sort then axistream_pack with random data -> every packed output word ascending, element count conserved.
